// File: rtl/jts16_pkg.sv
// -----------------------------------------------------------------------------
// jts16_pkg
// Shared definitions for the S16 ROM read slot:
//   LINE_W       - cache line width in bits (two 16-bit SDRAM words)
//   SDRAM_AW     - SDRAM word-address width
//   slot_state_t - fetch FSM state encoding (IDLE / REQ / WAIT)
//   sub_bits()   - number of client address bits that select inside a line
// -----------------------------------------------------------------------------
package jts16_pkg;

  localparam int LINE_W   = 32;
  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } slot_state_t;

  // A 32-bit line holds 4 bytes, 2 words or 1 longword.
  function automatic int sub_bits(input int dw);
    return (dw == 8) ? 2 : ((dw == 16) ? 1 : 0);
  endfunction

endpackage

// File: rtl/jts16_slot_line.sv
// -----------------------------------------------------------------------------
// jts16_slot_line
// One cache entry of the ROM slot: valid bit, line tag and 32-bit line data,
// plus the tag compare and the sub-word select for the client width.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_clr        invalidate the entry (wins over a simultaneous write)
//   i_we         write i_wtag / i_wdata and mark valid
//   i_wtag       tag to store
//   i_wdata      line data to store (bits 15:0 = even SDRAM word)
//   i_la         client line address to compare against the stored tag
//   i_sub        client sub-word index inside the line
//   o_hit        entry valid and tag matches i_la
//   o_dout       selected DW-bit slice of the stored line
// -----------------------------------------------------------------------------
module jts16_slot_line
  import jts16_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TW   = 17,
  parameter int SUBW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [TW-1:0]     i_wtag,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [TW-1:0]     i_la,
  input  logic [SUBW-1:0]   i_sub,
  output logic              o_hit,
  output logic [DW-1:0]     o_dout
);

  logic              r_valid;
  logic [TW-1:0]     r_tag;
  logic [LINE_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
      r_tag   <= i_wtag;
      r_data  <= i_wdata;
    end
  end

  assign o_hit = r_valid && (r_tag == i_la);

  generate
    if (DW == LINE_W) begin : g_full
      assign o_dout = r_data;
    end else begin : g_part
      // Index 0 is the least significant slice (even word / lowest byte).
      assign o_dout = r_data[i_sub*DW +: DW];
    end
  endgenerate

endmodule

// File: rtl/jts16_rom_slot.sv
// -----------------------------------------------------------------------------
// jts16_rom_slot
// Single-client read slot in front of one SDRAM bank port. Client reads are
// served from a two-entry 32-bit line cache; a miss issues one SDRAM read
// (req/ack/rdy), fills the least recently used entry and then answers.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   addr         client address in units of DW
//   cs           client read request, held until ok
//   clr          invalidate both cache entries
//   dout, ok     registered read data and its valid flag for the current addr
//   sdram_addr   SDRAM 16-bit word address of the line (OFFSET + 2*line)
//   sdram_req    read request, held until sdram_ack
//   sdram_ack    request accepted pulse
//   data_rdy     data_read valid pulse
//   data_read    32-bit line from SDRAM, bits 15:0 = even word
// -----------------------------------------------------------------------------
module jts16_rom_slot
  import jts16_pkg::*;
#(
  parameter int                  DW     = 16,
  parameter int                  AW     = 18,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       addr,
  input  logic                cs,
  input  logic                clr,
  output logic [DW-1:0]       dout,
  output logic                ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [LINE_W-1:0]   data_read
);

  localparam int SUBN = sub_bits(DW);
  localparam int SUBW = (SUBN > 0) ? SUBN : 1;
  localparam int TW   = AW - SUBN;

  slot_state_t         r_state;
  logic [TW-1:0]       r_ptag;
  logic                r_sdram_req;
  logic [SDRAM_AW-1:0] r_sdram_addr;
  logic                r_ok;
  logic [DW-1:0]       r_dout;
  logic                r_lru;      // entry to replace on the next fill
  logic                r_discard;  // clr seen while waiting: drop the fill

  logic [TW-1:0]       w_la;
  logic [SUBW-1:0]     w_sub;
  logic [1:0]          w_hit_v;
  logic [1:0]          w_we;
  logic [DW-1:0]       w_line_dout [2];
  logic                w_hit;
  logic [DW-1:0]       w_hit_data;
  logic                w_fill;
  logic [SDRAM_AW-1:0] w_word;
  logic [SDRAM_AW-1:0] w_sum;
  logic [SDRAM_AW-1:0] w_req_addr;

  assign w_la = addr[AW-1:SUBN];

  generate
    if (SUBN > 0) begin : g_sub
      assign w_sub = addr[SUBN-1:0];
    end else begin : g_nosub
      assign w_sub = '0;
    end
  endgenerate

  // Line address to SDRAM word address; bit 0 forced low so requests stay
  // line aligned even if OFFSET were odd.
  assign w_word     = SDRAM_AW'({w_la, 1'b0});
  assign w_sum      = OFFSET + w_word;
  assign w_req_addr = w_sum & {{(SDRAM_AW-1){1'b1}}, 1'b0};

  // Fill lands only if no clr arrived during the wait, including this cycle.
  assign w_fill = (r_state == ST_WAIT) && data_rdy && !clr && !r_discard;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      assign w_we[gi] = w_fill && (r_lru == 1'(gi));

      jts16_slot_line #(
        .DW   (DW),
        .TW   (TW),
        .SUBW (SUBW)
      ) u_line (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr),
        .i_we    (w_we[gi]),
        .i_wtag  (r_ptag),
        .i_wdata (data_read),
        .i_la    (w_la),
        .i_sub   (w_sub),
        .o_hit   (w_hit_v[gi]),
        .o_dout  (w_line_dout[gi])
      );
    end
  endgenerate

  assign w_hit      = |w_hit_v;
  assign w_hit_data = w_hit_v[0] ? w_line_dout[0] : w_line_dout[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptag       <= '0;
      r_sdram_req  <= 1'b0;
      r_sdram_addr <= OFFSET;
      r_ok         <= 1'b0;
      r_dout       <= '0;
      r_lru        <= 1'b0;
      r_discard    <= 1'b0;
    end else begin
      r_ok <= cs && w_hit && !clr;
      if (w_hit) r_dout <= w_hit_data;
      // A client hit makes the other entry the replacement candidate.
      if (cs && w_hit) r_lru <= w_hit_v[0];

      case (r_state)
        ST_IDLE: begin
          r_discard <= 1'b0;
          if (cs && !w_hit) begin
            r_state      <= ST_REQ;
            r_ptag       <= w_la;
            r_sdram_addr <= w_req_addr;
            r_sdram_req  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (clr) r_discard <= 1'b1;
          if (data_rdy) begin
            r_state <= ST_IDLE;
            // Overrides any hit refresh this cycle: the new line is freshest.
            if (w_fill) r_lru <= ~r_lru;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sdram_req <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign ok         = r_ok;
  assign sdram_addr = r_sdram_addr;
  assign sdram_req  = r_sdram_req;

endmodule

// File: tb/tb_jts16_rom_slot.sv
// -----------------------------------------------------------------------------
// tb_jts16_rom_slot
// Two slots share one driver: sel=0 drives a DW=16 slot at OFFSET 22'h8000,
// sel=1 drives a DW=8 slot at OFFSET 0. Expected SDRAM addresses and read data
// are queued when a read is issued and compared when the slot raises
// sdram_req / ok. A small SDRAM model answers requests when resp_en is set.
// -----------------------------------------------------------------------------
module tb_jts16_rom_slot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [17:0] t_addr = '0;
  logic        t_cs = 1'b0, t_clr = 1'b0, t_ack = 1'b0, t_rdy = 1'b0;
  logic [31:0] t_data = '0;
  logic        resp_en = 1'b1;

  logic [15:0] a_dout;
  logic        a_ok, a_req;
  logic [21:0] a_saddr;
  logic [7:0]  b_dout;
  logic        b_ok, b_req;
  logic [21:0] b_saddr;

  logic        m_ok, m_req;
  logic [15:0] m_dout;
  logic [21:0] m_saddr;

  int n_chk = 0, n_fail = 0, n_ack = 0, n_rdy = 0;
  logic [21:0] exp_req[$];
  logic [15:0] exp_dat[$];

  always #5 clk = ~clk;

  jts16_rom_slot #(.DW(16), .AW(18), .OFFSET(22'h8000)) u16 (
    .clk(clk), .rst(rst), .addr(t_addr), .cs(t_cs && !sel), .clr(t_clr && !sel),
    .dout(a_dout), .ok(a_ok), .sdram_addr(a_saddr), .sdram_req(a_req),
    .sdram_ack(t_ack && !sel), .data_rdy(t_rdy && !sel), .data_read(t_data));

  jts16_rom_slot #(.DW(8), .AW(18), .OFFSET(22'h0)) u8 (
    .clk(clk), .rst(rst), .addr(t_addr), .cs(t_cs && sel), .clr(t_clr && sel),
    .dout(b_dout), .ok(b_ok), .sdram_addr(b_saddr), .sdram_req(b_req),
    .sdram_ack(t_ack && sel), .data_rdy(t_rdy && sel), .data_read(t_data));

  assign m_ok    = sel ? b_ok    : a_ok;
  assign m_req   = sel ? b_req   : a_req;
  assign m_saddr = sel ? b_saddr : a_saddr;
  assign m_dout  = sel ? {8'h00, b_dout} : a_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // SDRAM contents, 16-bit words.
  function automatic logic [15:0] mem(input logic [21:0] a);
    if (a == 22'h8004) return 16'h1234;
    if (a == 22'h8005) return 16'hBEEF;
    return (a[15:0] * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [21:0] exp_saddr(input logic s, input logic [17:0] a);
    if (!s) return 22'h8000 + 22'({a[17:1], 1'b0});
    return 22'({a[17:2], 1'b0});
  endfunction

  function automatic logic [15:0] exp_dout(input logic s, input logic [17:0] a);
    logic [15:0] w;
    if (!s) return mem(exp_saddr(s, a) + 22'(a[0]));
    w = mem(exp_saddr(s, a) + 22'(a[1]));
    return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  // SDRAM responder: ack two cycles after req, data three cycles after ack.
  logic [21:0] cap;
  initial forever begin
    @(negedge clk);
    if (resp_en && m_req) begin
      cap = m_saddr;
      repeat (2) @(negedge clk);
      chk("saddr_stable", m_saddr, cap);
      t_ack = 1'b1; n_ack++;
      @(negedge clk);
      t_ack = 1'b0;
      chk("req_drop_after_ack", m_req, 1'b0);
      repeat (3) @(negedge clk);
      t_data = {mem(cap + 22'd1), mem(cap)};
      t_rdy = 1'b1; n_rdy++;
      @(negedge clk);
      t_rdy = 1'b0;
    end
  end

  // Scoreboard monitor.
  logic req_q = 1'b0, ok_q = 1'b0;
  initial forever begin
    @(negedge clk);
    if (m_req && !req_q) begin
      $display("req sel=%0d sdram_addr=%h", sel, m_saddr);
      chk("req_expected", exp_req.size() != 0, 1'b1);
      if (exp_req.size() != 0) chk("sdram_addr", m_saddr, exp_req.pop_front());
    end
    if (m_ok && !ok_q) begin
      $display("rd  sel=%0d addr=%h dout=%h", sel, t_addr, m_dout);
      chk("ok_expected", exp_dat.size() != 0, 1'b1);
      if (exp_dat.size() != 0) chk("dout", m_dout, exp_dat.pop_front());
    end
    req_q = m_req;
    ok_q  = m_ok;
  end

  task automatic wait_ok(output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (m_ok) got = 1;
    end
    chk("ok_seen", got, 1'b1);
  endtask

  task automatic rd(input logic [17:0] a, input bit miss, output int lat);
    @(negedge clk);
    exp_dat.push_back(exp_dout(sel, a));
    if (miss) exp_req.push_back(exp_saddr(sel, a));
    t_addr = a;
    t_cs   = 1'b1;
    wait_ok(lat);
    t_cs = 1'b0;
    @(negedge clk);
    chk("ok_drop", m_ok, 1'b0);
  endtask

  task automatic wait_ack(input int k);
    for (int i = 0; i < 50 && n_ack == k; i++) @(negedge clk);
    chk("ack_seen", n_ack != k, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, k;
    repeat (3) @(negedge clk);
    chk("rst_ok", a_ok, 1'b0);
    chk("rst_dout", a_dout, 16'h0);
    chk("rst_req", a_req, 1'b0);
    chk("rst_saddr16", a_saddr, 22'h8000);
    chk("rst_saddr8", b_saddr, 22'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // DW=16 miss then same-line hit.
    rd(18'h00005, 1, lat);
    rd(18'h00004, 0, lat);
    chk("hit_latency", lat, 1);

    // DW=8 LRU: A, B, A, C evicts B; A still hits, B misses again.
    @(negedge clk); sel = 1'b1;
    rd(18'h00005, 1, lat);
    rd(18'h00009, 1, lat);
    rd(18'h00006, 0, lat);
    rd(18'h0000D, 1, lat);
    rd(18'h00007, 0, lat);
    rd(18'h00008, 1, lat);
    @(negedge clk); sel = 1'b0;

    // Address change while waiting: first fill completes, ok only for second.
    @(negedge clk);
    k = n_ack;
    exp_req.push_back(exp_saddr(1'b0, 18'h00100));
    t_addr = 18'h00100; t_cs = 1'b1;
    wait_ack(k);
    @(negedge clk);
    exp_req.push_back(exp_saddr(1'b0, 18'h00202));
    exp_dat.push_back(exp_dout(1'b0, 18'h00202));
    t_addr = 18'h00202;
    wait_ok(lat);
    t_cs = 1'b0;
    @(negedge clk);

    // clr while waiting: fill dropped, same line requested again.
    @(negedge clk);
    k = n_rdy;
    exp_req.push_back(exp_saddr(1'b0, 18'h00300));
    exp_req.push_back(exp_saddr(1'b0, 18'h00300));
    exp_dat.push_back(exp_dout(1'b0, 18'h00300));
    t_addr = 18'h00300; t_cs = 1'b1;
    wait_ack(n_ack);
    @(negedge clk); t_clr = 1'b1;
    @(negedge clk); t_clr = 1'b0;
    wait_ok(lat);
    chk("clr_two_fills", n_rdy - k, 2);
    t_cs = 1'b0;
    @(negedge clk);

    // Reset during REQ, then a stray data_rdy.
    resp_en = 1'b0;
    @(negedge clk);
    exp_req.push_back(exp_saddr(1'b0, 18'h00040));
    t_addr = 18'h00040; t_cs = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (m_req) got = 1;
      end
      chk("req_seen", got, 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", m_req, 1'b0);
    chk("rst_async_ok", m_ok, 1'b0);
    chk("rst_async_saddr", m_saddr, 22'h8000);
    @(negedge clk); rst = 1'b0; t_cs = 1'b0;
    @(negedge clk); t_data = 32'hDEAD_BEEF; t_rdy = 1'b1;
    @(negedge clk); t_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_rdy_ok", m_ok, 1'b0);
    chk("stray_rdy_req", m_req, 1'b0);

    chk("req_queue_empty", exp_req.size(), 0);
    chk("dat_queue_empty", exp_dat.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
